// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared state and fault-source encodings for the bus fault monitor
package bus_pkg;

  // Width of the shared wait/watchdog cycle counter; covers TIMEOUT up to 65535.
  localparam int unsigned CTR_W = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WAIT  = 3'd1,
    WATCH = 3'd2,
    ERR   = 3'd3,
    DONE  = 3'd4
  } bus_state_e;

  typedef enum logic {
    SRC_UNMAPPED = 1'b0,
    SRC_TIMEOUT  = 1'b1
  } fault_src_e;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  // Clear wins over increment; the count sticks at all-ones once reached.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/bus_fault.sv
// rtl/bus_fault.sv - 68k bus error generator for unmapped regions and DTACK watchdog
module bus_fault
  import bus_pkg::*;
#(
  parameter int unsigned ADDR_W   = 24,
  parameter int unsigned NREG     = 4,
  parameter int unsigned WAIT_CYC = 2,
  parameter int unsigned TIMEOUT  = 64,
  parameter int unsigned CNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              as_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic [2:0]        fc,
  input  logic              rw,
  input  logic [NREG-1:0]   region_en,
  input  logic              dtack_in_n,
  output logic              berr_n,
  output logic              berr_oe,
  output logic              fault_valid,
  output logic [ADDR_W-1:0] fault_addr,
  output logic [2:0]        fault_fc,
  output logic              fault_rw,
  output logic              fault_src,
  input  logic              fault_clr,
  output logic [CNT_W-1:0]  fault_count
);

  localparam logic [CTR_W-1:0] WAIT_LD = CTR_W'(WAIT_CYC);
  localparam logic [CTR_W-1:0] TO_LAST = CTR_W'(TIMEOUT - 1);

  bus_state_e          state_q, state_d;
  logic [CTR_W-1:0]    cnt_q, cnt_d;
  logic                as_prev_q;
  logic                cycle_start;
  logic                err_entry;
  logic [ADDR_W-1:0]   cyc_addr_q;
  logic [2:0]          cyc_fc_q;
  logic                cyc_rw_q;
  logic                fault_valid_q, fault_valid_d;
  logic [ADDR_W-1:0]   fault_addr_q, fault_addr_d;
  logic [2:0]          fault_fc_q, fault_fc_d;
  logic                fault_rw_q, fault_rw_d;
  fault_src_e          fault_src_q, fault_src_d;
  logic                berr_oe_q;

  // as_prev_q resets low so a cycle already under way at reset release is not
  // mistaken for a fresh strobe; a high sample must be seen first.
  assign cycle_start = as_prev_q && !as_n;
  assign err_entry   = (state_d == ERR) && (state_q != ERR);

  // Next-state and counter: wait-count for unmapped hits, count-up watchdog otherwise.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (cycle_start) begin
          if (|region_en) begin
            state_d = WAIT;
            cnt_d   = WAIT_LD;
          end else begin
            state_d = WATCH;
            cnt_d   = '0;
          end
        end
      end
      WAIT: begin
        if (as_n) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = ERR;
        end else begin
          cnt_d = cnt_q - CTR_W'(1);
        end
      end
      WATCH: begin
        if (as_n) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (!dtack_in_n) begin
          state_d = DONE;
          cnt_d   = '0;
        end else if (cnt_q == TO_LAST) begin
          state_d = ERR;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CTR_W'(1);
        end
      end
      ERR: begin
        if (as_n) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      DONE: begin
        if (as_n) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Fault record: first fault wins unless a clear lands on the same clock as a new one.
  always_comb begin
    fault_valid_d = fault_valid_q;
    fault_addr_d  = fault_addr_q;
    fault_fc_d    = fault_fc_q;
    fault_rw_d    = fault_rw_q;
    fault_src_d   = fault_src_q;
    if (err_entry && (!fault_valid_q || fault_clr)) begin
      fault_valid_d = 1'b1;
      fault_addr_d  = cyc_addr_q;
      fault_fc_d    = cyc_fc_q;
      fault_rw_d    = cyc_rw_q;
      fault_src_d   = (state_q == WAIT) ? SRC_UNMAPPED : SRC_TIMEOUT;
    end else if (fault_clr) begin
      fault_valid_d = 1'b0;
    end
  end

  // State, counter, strobe history and registered bus error drive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      as_prev_q <= 1'b0;
      berr_oe_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      as_prev_q <= as_n;
      berr_oe_q <= (state_d == ERR);
    end
  end

  // Bus attributes are latched at the strobe so late address changes do not leak into the record.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_addr_q <= '0;
      cyc_fc_q   <= '0;
      cyc_rw_q   <= 1'b0;
    end else if ((state_q == IDLE) && cycle_start) begin
      cyc_addr_q <= addr;
      cyc_fc_q   <= fc;
      cyc_rw_q   <= rw;
    end
  end

  // Fault record registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_valid_q <= 1'b0;
      fault_addr_q  <= '0;
      fault_fc_q    <= '0;
      fault_rw_q    <= 1'b0;
      fault_src_q   <= SRC_UNMAPPED;
    end else begin
      fault_valid_q <= fault_valid_d;
      fault_addr_q  <= fault_addr_d;
      fault_fc_q    <= fault_fc_d;
      fault_rw_q    <= fault_rw_d;
      fault_src_q   <= fault_src_d;
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_fault_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (err_entry),
    .clr   (1'b0),
    .count (fault_count)
  );

  assign berr_oe     = berr_oe_q;
  assign berr_n      = ~berr_oe_q;
  assign fault_valid = fault_valid_q;
  assign fault_addr  = fault_addr_q;
  assign fault_fc    = fault_fc_q;
  assign fault_rw    = fault_rw_q;
  assign fault_src   = fault_src_q;

endmodule

// File: tb/tb_bus_fault.sv
// tb/tb_bus_fault.sv - directed self-checking bench for bus_fault
module tb_bus_fault;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        as_n = 1'b1;
  logic [23:0] addr = '0;
  logic [2:0]  fc = '0;
  logic        rw = 1'b0;
  logic [3:0]  region_en = '0;
  logic        dtack_in_n = 1'b1;
  logic        fault_clr = 1'b0;

  logic        berr_n, berr_oe, fault_valid, fault_rw, fault_src;
  logic [23:0] fault_addr;
  logic [2:0]  fault_fc;
  logic [7:0]  fault_count;

  logic        s_berr_n, s_berr_oe, s_fault_valid, s_fault_rw, s_fault_src;
  logic [23:0] s_fault_addr;
  logic [2:0]  s_fault_fc;
  logic [1:0]  s_fault_count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bus_fault u_dut (
    .clk(clk), .rst_n(rst_n), .as_n(as_n), .addr(addr), .fc(fc), .rw(rw),
    .region_en(region_en), .dtack_in_n(dtack_in_n),
    .berr_n(berr_n), .berr_oe(berr_oe), .fault_valid(fault_valid),
    .fault_addr(fault_addr), .fault_fc(fault_fc), .fault_rw(fault_rw),
    .fault_src(fault_src), .fault_clr(fault_clr), .fault_count(fault_count)
  );

  bus_fault #(.CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .as_n(as_n), .addr(addr), .fc(fc), .rw(rw),
    .region_en(region_en), .dtack_in_n(dtack_in_n),
    .berr_n(s_berr_n), .berr_oe(s_berr_oe), .fault_valid(s_fault_valid),
    .fault_addr(s_fault_addr), .fault_fc(s_fault_fc), .fault_rw(s_fault_rw),
    .fault_src(s_fault_src), .fault_clr(fault_clr), .fault_count(s_fault_count)
  );

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; as_n = 1'b1; region_en = '0; dtack_in_n = 1'b1;
    fault_clr = 1'b0; addr = '0; fc = '0; rw = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic run_fault(input logic [23:0] a, input logic clr);
    addr = a; fc = 3'd5; rw = 1'b1; region_en = 4'b0001; as_n = 1'b0;
    step(3);
    fault_clr = clr;
    step(1);
    fault_clr = 1'b0;
    as_n = 1'b1; region_en = '0;
    step(1);
  endtask

  task automatic test_reset();
    step(2);
    checks++; if (berr_n !== 1'b1) begin failures++; $display("FAIL reset_berr_n got=%b exp=1", berr_n); end
    checks++; if (berr_oe !== 1'b0) begin failures++; $display("FAIL reset_berr_oe got=%b exp=0", berr_oe); end
    checks++; if (fault_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", fault_valid); end
    checks++; if (fault_addr !== 24'h0) begin failures++; $display("FAIL reset_addr got=%h exp=000000", fault_addr); end
    checks++; if (fault_count !== 8'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", fault_count); end
    checks++; if (s_fault_count !== 2'd0) begin failures++; $display("FAIL reset_sat_count got=%0d exp=0", s_fault_count); end
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic test_unmapped();
    addr = 24'h000100; fc = 3'd6; rw = 1'b0; region_en = 4'b0001; as_n = 1'b0;
    step(1);
    region_en = 4'b0000;
    step(2);
    checks++; if (berr_n !== 1'b1) begin failures++; $display("FAIL unm_early_berr got=%b exp=1", berr_n); end
    step(1);
    checks++; if (berr_n !== 1'b0) begin failures++; $display("FAIL unm_berr_n got=%b exp=0", berr_n); end
    checks++; if (berr_oe !== 1'b1) begin failures++; $display("FAIL unm_berr_oe got=%b exp=1", berr_oe); end
    checks++; if (fault_valid !== 1'b1) begin failures++; $display("FAIL unm_valid got=%b exp=1", fault_valid); end
    checks++; if (fault_addr !== 24'h000100) begin failures++; $display("FAIL unm_addr got=%h exp=000100", fault_addr); end
    checks++; if (fault_fc !== 3'd6) begin failures++; $display("FAIL unm_fc got=%0d exp=6", fault_fc); end
    checks++; if (fault_rw !== 1'b0) begin failures++; $display("FAIL unm_rw got=%b exp=0", fault_rw); end
    checks++; if (fault_src !== 1'b0) begin failures++; $display("FAIL unm_src got=%b exp=0", fault_src); end
    checks++; if (fault_count !== 8'd1) begin failures++; $display("FAIL unm_count got=%0d exp=1", fault_count); end
    step(2);
    checks++; if (berr_n !== 1'b0) begin failures++; $display("FAIL unm_hold_berr got=%b exp=0", berr_n); end
    as_n = 1'b1;
    step(1);
    checks++; if (berr_oe !== 1'b0 || berr_n !== 1'b1) begin failures++; $display("FAIL unm_release got oe=%b n=%b exp oe=0 n=1", berr_oe, berr_n); end
  endtask

  task automatic test_dtack();
    logic saw;
    saw = 1'b0;
    addr = 24'h000200; region_en = 4'b0000; as_n = 1'b0;
    step(1);
    region_en = 4'b0010;
    step(4);
    if (!berr_n) saw = 1'b1;
    dtack_in_n = 1'b0;
    step(1);
    dtack_in_n = 1'b1;
    for (int i = 0; i < 80; i++) begin
      step(1);
      if (!berr_n || berr_oe) saw = 1'b1;
    end
    checks++; if (saw !== 1'b0) begin failures++; $display("FAIL dtack_no_berr got=%b exp=0", saw); end
    checks++; if (fault_count !== 8'd1) begin failures++; $display("FAIL dtack_count got=%0d exp=1", fault_count); end
    as_n = 1'b1; region_en = '0;
    step(1);
  endtask

  task automatic test_timeout();
    fault_clr = 1'b1;
    step(1);
    fault_clr = 1'b0;
    checks++; if (fault_valid !== 1'b0) begin failures++; $display("FAIL clr_valid got=%b exp=0", fault_valid); end
    addr = 24'h002000; fc = 3'd2; rw = 1'b1; region_en = '0; as_n = 1'b0;
    step(64);
    checks++; if (berr_n !== 1'b1) begin failures++; $display("FAIL to_early_berr got=%b exp=1", berr_n); end
    step(1);
    checks++; if (berr_n !== 1'b0) begin failures++; $display("FAIL to_berr_n got=%b exp=0", berr_n); end
    checks++; if (fault_src !== 1'b1) begin failures++; $display("FAIL to_src got=%b exp=1", fault_src); end
    checks++; if (fault_addr !== 24'h002000) begin failures++; $display("FAIL to_addr got=%h exp=002000", fault_addr); end
    checks++; if (fault_count !== 8'd2) begin failures++; $display("FAIL to_count got=%0d exp=2", fault_count); end
    step(3);
    checks++; if (berr_oe !== 1'b1) begin failures++; $display("FAIL to_hold_oe got=%b exp=1", berr_oe); end
    as_n = 1'b1;
    step(1);
    checks++; if (berr_oe !== 1'b0 || berr_n !== 1'b1) begin failures++; $display("FAIL to_release got oe=%b n=%b exp oe=0 n=1", berr_oe, berr_n); end
  endtask

  task automatic test_multi();
    apply_reset();
    run_fault(24'h000100, 1'b0);
    run_fault(24'h00F000, 1'b0);
    checks++; if (fault_addr !== 24'h000100) begin failures++; $display("FAIL multi_keep_addr got=%h exp=000100", fault_addr); end
    checks++; if (fault_count !== 8'd2) begin failures++; $display("FAIL multi_count2 got=%0d exp=2", fault_count); end
    run_fault(24'h0ABCDE, 1'b1);
    checks++; if (fault_addr !== 24'h0ABCDE) begin failures++; $display("FAIL multi_clr_addr got=%h exp=0abcde", fault_addr); end
    checks++; if (fault_valid !== 1'b1) begin failures++; $display("FAIL multi_clr_valid got=%b exp=1", fault_valid); end
    checks++; if (fault_count !== 8'd3) begin failures++; $display("FAIL multi_count3 got=%0d exp=3", fault_count); end
  endtask

  task automatic test_abort();
    logic saw;
    saw = 1'b0;
    fault_clr = 1'b1;
    step(1);
    fault_clr = 1'b0;
    region_en = 4'b0100; addr = 24'h000400; as_n = 1'b0;
    for (int i = 0; i < 2; i++) begin step(1); if (!berr_n) saw = 1'b1; end
    as_n = 1'b1; region_en = '0;
    step(1);
    as_n = 1'b0;
    for (int i = 0; i < 10; i++) begin step(1); if (!berr_n) saw = 1'b1; end
    as_n = 1'b1;
    for (int i = 0; i < 5; i++) begin step(1); if (!berr_n) saw = 1'b1; end
    checks++; if (saw !== 1'b0) begin failures++; $display("FAIL abort_no_berr got=%b exp=0", saw); end
    checks++; if (fault_count !== 8'd3) begin failures++; $display("FAIL abort_count got=%0d exp=3", fault_count); end
    checks++; if (fault_valid !== 1'b0) begin failures++; $display("FAIL abort_valid got=%b exp=0", fault_valid); end
  endtask

  task automatic test_reset_mid_err();
    logic saw;
    saw = 1'b0;
    addr = 24'h000300; region_en = 4'b0001; as_n = 1'b0;
    step(4);
    checks++; if (berr_n !== 1'b0) begin failures++; $display("FAIL mid_in_err got=%b exp=0", berr_n); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (berr_n !== 1'b1 || berr_oe !== 1'b0) begin failures++; $display("FAIL mid_async got n=%b oe=%b exp n=1 oe=0", berr_n, berr_oe); end
    checks++; if (fault_valid !== 1'b0 || fault_addr !== 24'h0) begin failures++; $display("FAIL mid_record got v=%b a=%h exp v=0 a=000000", fault_valid, fault_addr); end
    checks++; if (fault_count !== 8'd0) begin failures++; $display("FAIL mid_count got=%0d exp=0", fault_count); end
    step(2);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin step(1); if (!berr_n) saw = 1'b1; end
    checks++; if (saw !== 1'b0) begin failures++; $display("FAIL mid_no_restart got=%b exp=0", saw); end
    as_n = 1'b1;
    step(1);
    as_n = 1'b0;
    step(4);
    checks++; if (berr_n !== 1'b0) begin failures++; $display("FAIL mid_new_cycle got=%b exp=0", berr_n); end
    checks++; if (fault_addr !== 24'h000300 || fault_count !== 8'd1) begin failures++; $display("FAIL mid_new_record got a=%h c=%0d exp a=000300 c=1", fault_addr, fault_count); end
    as_n = 1'b1; region_en = '0;
    step(1);
  endtask

  task automatic test_saturate();
    apply_reset();
    for (int i = 0; i < 5; i++) run_fault(24'h001000 + 24'(i), 1'b0);
    checks++; if (fault_count !== 8'd5) begin failures++; $display("FAIL sat_wide_count got=%0d exp=5", fault_count); end
    checks++; if (s_fault_count !== 2'd3) begin failures++; $display("FAIL sat_narrow_count got=%0d exp=3", s_fault_count); end
  endtask

  initial begin
    test_reset();
    test_unmapped();
    test_dtack();
    test_timeout();
    test_multi();
    test_abort();
    test_reset_mid_err();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bus_fault.md
BUS_FAULT -- requirements
Module: bus_fault

Interface
REQ-001 SHALL have parameter ADDR_W, default 24, width of captured bus address.
REQ-002 SHALL have parameter NREG, default 4, number of unmapped-region select inputs.
REQ-003 SHALL have parameter WAIT_CYC, default 2, clocks between unmapped-cycle detection and bus error.
REQ-004 SHALL have parameter TIMEOUT, default 64, clocks without acknowledge before watchdog bus error; legal range 2..65535.
REQ-005 SHALL have parameter CNT_W, default 8, width of fault counter.
REQ-006 SHALL have ports: clk  in  1  system clock, sole clock domain.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 as_n  in  1  68k address strobe, active low, synchronous to clk.
REQ-009 addr  in  ADDR_W  bus address.
REQ-010 fc  in  3  68k function code.
REQ-011 rw  in  1  68k read/write (1 = read).
REQ-012 region_en  in  NREG  one-hot-or-zero decode selects for unmapped regions.
REQ-013 dtack_in_n  in  1  wired DTACK from all other memory controllers, active low.
REQ-014 berr_n  out  1  bus error to CPU, active low.
REQ-015 berr_oe  out  1  high while berr_n must be driven; low means tri-state.
REQ-016 fault_valid  out  1  sticky flag: fault record held.
REQ-017 fault_addr / fault_fc / fault_rw  out  ADDR_W / 3 / 1  captured record of first fault.
REQ-018 fault_src  out  1  0 = unmapped region, 1 = watchdog timeout.
REQ-019 fault_clr  in  1  single-cycle pulse clearing fault_valid.
REQ-020 fault_count  out  CNT_W  saturating count of bus errors issued.

Function
REQ-021 Cycle start SHALL be as_n sampled low after being sampled high the previous clock.
REQ-022 FSM states SHALL be IDLE, WAIT, WATCH, ERR, DONE.
REQ-023 IDLE: on cycle start with any region_en bit set -> WAIT (counter loaded WAIT_CYC); otherwise -> WATCH (counter loaded 0).
REQ-024 WAIT: counter decrements each clock; at 0 -> ERR; WAIT_CYC=0 SHALL reach ERR on the clock after cycle start.
REQ-025 WATCH: dtack_in_n low -> DONE without error; counter reaching TIMEOUT-1 with dtack_in_n high -> ERR.
REQ-026 ERR: berr_n=0 and berr_oe=1 SHALL hold until as_n sampled high, then -> IDLE with berr_oe=0 the same clock.
REQ-027 DONE: stays until as_n sampled high, then -> IDLE.
REQ-028 as_n sampled high in WAIT or WATCH SHALL abort to IDLE without error or capture.
REQ-029 Outside ERR berr_n SHALL be 1 and berr_oe 0.
REQ-030 On entry to ERR with fault_valid=0, addr/fc/rw sampled at cycle start and fault_src SHALL be captured and fault_valid set.
REQ-031 On entry to ERR with fault_valid=1, record SHALL be unchanged.
REQ-032 fault_clr coinciding with ERR entry SHALL capture the new fault and leave fault_valid=1.
REQ-033 fault_count SHALL increment on each ERR entry and saturate at all-ones.
REQ-034 region_en changes after cycle start SHALL be ignored for that cycle.

Reset
REQ-035 rst_n low SHALL asynchronously force IDLE, berr_n=1, berr_oe=0, fault_valid=0, fault_addr/fc/rw/src=0, fault_count=0, counter=0, even mid-cycle.
REQ-036 After reset release, a cycle already in progress (as_n low) SHALL NOT be treated as a cycle start until as_n has been sampled high.

Structure
REQ-037 FSM state enum and fault_src encodings SHALL reside in shared package bus_pkg.
REQ-038 Saturating counter SHALL be sub-module sat_counter (parameter W, inputs inc/clr).

Verification
REQ-039 region_en=0001, addr=24'h000100, WAIT_CYC=2 -> berr_n low 3 clocks after cycle start, fault_addr=24'h000100, fault_src=0, fault_count=1.
REQ-040 region_en=0, dtack_in_n low 5 clocks after start -> no berr, DONE, fault_count unchanged.
REQ-041 region_en=0, no dtack, TIMEOUT=64 -> berr_n low 64 clocks after start, fault_src=1; released on as_n high.
REQ-042 Two faults, second at addr 24'h00F000 without clear -> fault_addr keeps first address, fault_count=2; fault_clr coincident with third fault -> record = third.
REQ-043 rst_n pulsed low during ERR -> berr_n=1, berr_oe=0 immediately; no new cycle until as_n high then low.
REQ-044 CNT_W=2, five faults -> fault_count=3.
